// File: rtl/scanline_buf_ctrl_pkg.sv
// Shared PPU scanline-buffer definitions: write-side state encoding, the black
// palette index shown before the first line lands, and the default line width.
package scanline_buf_ctrl_pkg;

  typedef enum logic [0:0] {
    SLB_FILL = 1'b0,
    SLB_FULL = 1'b1
  } slb_state_t;

  localparam logic [5:0] SLB_BLACK  = 6'h0F;
  localparam int         SLB_LINE_W = 256;

endpackage

// File: rtl/scanline_bank.sv
// One LINE_W x 6 scanline bank: synchronous write, asynchronous (combinational) read.
// Contents are deliberately not reset.
module scanline_bank
  import scanline_buf_ctrl_pkg::*;
#(
  parameter int LINE_W = SLB_LINE_W,
  parameter int AW     = $clog2(LINE_W)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [5:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [5:0]    o_rdata
);

  logic [5:0] r_mem [LINE_W];

  // Pixel storage write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end else begin
      r_mem[i_waddr] <= r_mem[i_waddr];
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/scanline_buf_ctrl.sv
// Ping-pong scanline buffer controller between the PPU pixel pipeline and the VGA scanner.
// Define SLBUF_STATS_EN to add the underrun counter, sticky overrun flag and stat_clr.
module scanline_buf_ctrl
  import scanline_buf_ctrl_pkg::*;
#(
  parameter int LINE_W = SLB_LINE_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clk_en,
  input  logic       i_ppu_wr_en,
  input  logic [7:0] i_ppu_wr_idx,
  input  logic [5:0] i_ppu_wr_data,
  input  logic       i_ppu_line_done,
  output logic       o_ppu_wr_ready,
  input  logic       i_vga_swap_req,
  input  logic [7:0] i_vga_buf_idx,
  output logic [5:0] o_vga_buf_out
`ifdef SLBUF_STATS_EN
  ,
  output logic [7:0] o_underrun_cnt,
  output logic       o_overrun,
  input  logic       i_stat_clr
`endif
);

  localparam int AW = $clog2(LINE_W);

  slb_state_t    r_state;
  slb_state_t    w_state_nxt;
  logic          r_rd_sel;
  logic          w_rd_sel_nxt;
  logic          r_primed;
  logic          w_primed_nxt;
  logic          w_wr_ok;
  logic          w_underrun;
  logic          w_overrun;
  logic          w_we0;
  logic          w_we1;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;
  logic [5:0]    w_rdata0;
  logic [5:0]    w_rdata1;
  logic          w_unused_idx;

  // Short lines use only the low index bits, so writes wrap
  assign w_wr_addr    = i_ppu_wr_idx[AW-1:0];
  assign w_rd_addr    = i_vga_buf_idx[AW-1:0];
  assign w_unused_idx = ^{i_ppu_wr_idx, i_vga_buf_idx};

  // Write-side FSM next state, swap decision and event flags
  always_comb begin
    w_state_nxt  = r_state;
    w_rd_sel_nxt = r_rd_sel;
    w_primed_nxt = r_primed;
    w_wr_ok      = 1'b0;
    w_underrun   = 1'b0;
    w_overrun    = 1'b0;
    case (r_state)
      SLB_FILL: begin
        w_wr_ok = i_ppu_wr_en;
        if (i_ppu_line_done) begin
          if (i_vga_swap_req) begin
            // Commit and swap in one cycle: keep filling the freshly freed bank
            w_rd_sel_nxt = ~r_rd_sel;
            w_primed_nxt = 1'b1;
            w_state_nxt  = SLB_FILL;
          end else begin
            w_state_nxt  = SLB_FULL;
          end
        end else if (i_vga_swap_req) begin
          w_underrun = 1'b1;
        end else begin
          w_underrun = 1'b0;
        end
      end
      SLB_FULL: begin
        if (i_ppu_wr_en || i_ppu_line_done) begin
          w_overrun = 1'b1;
        end else begin
          w_overrun = 1'b0;
        end
        if (i_vga_swap_req) begin
          w_rd_sel_nxt = ~r_rd_sel;
          w_primed_nxt = 1'b1;
          w_state_nxt  = SLB_FILL;
        end else begin
          w_state_nxt  = SLB_FULL;
        end
      end
      default: begin
        w_state_nxt = SLB_FILL;
      end
    endcase
  end

  // Write bank is always the one not being read, sampled before any swap
  assign w_we0 = i_clk_en & w_wr_ok &  r_rd_sel;
  assign w_we1 = i_clk_en & w_wr_ok & ~r_rd_sel;

  // Controller state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= SLB_FILL;
      r_rd_sel <= 1'b1;
      r_primed <= 1'b0;
    end else if (i_clk_en) begin
      r_state  <= w_state_nxt;
      r_rd_sel <= w_rd_sel_nxt;
      r_primed <= w_primed_nxt;
    end else begin
      r_state  <= r_state;
      r_rd_sel <= r_rd_sel;
      r_primed <= r_primed;
    end
  end

  assign o_ppu_wr_ready = (r_state == SLB_FILL);

  scanline_bank #(.LINE_W(LINE_W), .AW(AW)) u_bank0 (
    .clk     (clk),
    .i_we    (w_we0),
    .i_waddr (w_wr_addr),
    .i_wdata (i_ppu_wr_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata0)
  );

  scanline_bank #(.LINE_W(LINE_W), .AW(AW)) u_bank1 (
    .clk     (clk),
    .i_we    (w_we1),
    .i_waddr (w_wr_addr),
    .i_wdata (i_ppu_wr_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata1)
  );

  assign o_vga_buf_out = r_primed ? (r_rd_sel ? w_rdata1 : w_rdata0) : SLB_BLACK;

`ifdef SLBUF_STATS_EN
  logic [7:0] r_underrun_cnt;
  logic       r_overrun;

  // Statistics; clear wins over a same-cycle increment or set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underrun_cnt <= 8'd0;
      r_overrun      <= 1'b0;
    end else if (i_clk_en) begin
      if (i_stat_clr) begin
        r_underrun_cnt <= 8'd0;
        r_overrun      <= 1'b0;
      end else begin
        if (w_underrun && (r_underrun_cnt != 8'hFF)) begin
          r_underrun_cnt <= r_underrun_cnt + 8'd1;
        end else begin
          r_underrun_cnt <= r_underrun_cnt;
        end
        r_overrun <= r_overrun | w_overrun;
      end
    end else begin
      r_underrun_cnt <= r_underrun_cnt;
      r_overrun      <= r_overrun;
    end
  end

  assign o_underrun_cnt = r_underrun_cnt;
  assign o_overrun      = r_overrun;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_underrun | w_overrun;
`endif

endmodule

// File: tb/tb_scanline_buf_ctrl.sv
// Scoreboard bench for scanline_buf_ctrl: stimulus pushes expected values, a
// negedge monitor pops and compares. Statistics checks need SLBUF_STATS_EN.
module tb_scanline_buf_ctrl;
  import scanline_buf_ctrl_pkg::*;

  localparam int K_OUT = 0;
  localparam int K_RDY = 1;
  localparam int K_UND = 2;
  localparam int K_OVR = 3;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } sb_entry_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_clk_en;
  logic       i_ppu_wr_en;
  logic [7:0] i_ppu_wr_idx;
  logic [5:0] i_ppu_wr_data;
  logic       i_ppu_line_done;
  logic       o_ppu_wr_ready;
  logic       i_vga_swap_req;
  logic [7:0] i_vga_buf_idx;
  logic [5:0] o_vga_buf_out;
  logic [7:0] o_underrun_cnt;
  logic       o_overrun;
  logic       i_stat_clr;

  sb_entry_t  sb_q[$];
  sb_entry_t  mon_e;
  logic [7:0] mon_act;
  logic       obs_valid = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  scanline_buf_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_clk_en        (i_clk_en),
    .i_ppu_wr_en     (i_ppu_wr_en),
    .i_ppu_wr_idx    (i_ppu_wr_idx),
    .i_ppu_wr_data   (i_ppu_wr_data),
    .i_ppu_line_done (i_ppu_line_done),
    .o_ppu_wr_ready  (o_ppu_wr_ready),
    .i_vga_swap_req  (i_vga_swap_req),
    .i_vga_buf_idx   (i_vga_buf_idx),
    .o_vga_buf_out   (o_vga_buf_out)
`ifdef SLBUF_STATS_EN
    ,
    .o_underrun_cnt  (o_underrun_cnt),
    .o_overrun       (o_overrun),
    .i_stat_clr      (i_stat_clr)
`endif
  );

`ifndef SLBUF_STATS_EN
  assign o_underrun_cnt = 8'd0;
  assign o_overrun      = 1'b0;
`endif

  // Monitor: pop one expectation per presented observation and compare
  always @(negedge clk) begin
    if (obs_valid) begin
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: observation with no expected value");
      end else begin
        mon_e = sb_q.pop_front();
        checks++;
        case (mon_e.kind)
          K_OUT:   mon_act = {2'b00, o_vga_buf_out};
          K_RDY:   mon_act = {7'b0, o_ppu_wr_ready};
          K_UND:   mon_act = o_underrun_cnt;
          K_OVR:   mon_act = {7'b0, o_overrun};
          default: mon_act = 8'hXX;
        endcase
        if (mon_act !== mon_e.exp) begin
          errors++;
          $display("FAIL %s: got 0x%02h expected 0x%02h", mon_e.name, mon_act, mon_e.exp);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int kind, input logic [7:0] exp, input string nm);
    sb_q.push_back('{kind: kind, exp: exp, name: nm});
    obs_valid = 1'b1;
    @(negedge clk);
    #1;
    obs_valid = 1'b0;
  endtask

  task automatic expect_out(input logic [7:0] idx, input logic [5:0] exp, input string nm);
    i_vga_buf_idx = idx;
    expect_v(K_OUT, {2'b00, exp}, nm);
  endtask

  task automatic write_px(input logic [7:0] idx, input logic [5:0] data);
    i_ppu_wr_en   = 1'b1;
    i_ppu_wr_idx  = idx;
    i_ppu_wr_data = data;
    tick();
    i_ppu_wr_en   = 1'b0;
  endtask

  task automatic pulse_done();
    i_ppu_line_done = 1'b1;
    tick();
    i_ppu_line_done = 1'b0;
  endtask

  task automatic pulse_swap();
    i_vga_swap_req = 1'b1;
    tick();
    i_vga_swap_req = 1'b0;
  endtask

  task automatic pulse_clr();
    i_stat_clr = 1'b1;
    tick();
    i_stat_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_clk_en = 1'b1; i_ppu_wr_en = 1'b0; i_ppu_wr_idx = 8'd0;
    i_ppu_wr_data = 6'd0; i_ppu_line_done = 1'b0; i_vga_swap_req = 1'b0;
    i_vga_buf_idx = 8'd0; i_stat_clr = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    expect_out(8'd5, 6'h0F, "reset_out_black");
    expect_v(K_RDY, 8'd1, "reset_ready");
`ifdef SLBUF_STATS_EN
    expect_v(K_UND, 8'd0, "reset_underrun");
    expect_v(K_OVR, 8'd0, "reset_overrun");
`endif

    // Ramp line: data = idx & 0x3F
    for (int i = 0; i < 256; i++) write_px(8'(i), 6'(i & 8'h3F));
    pulse_done();
    expect_v(K_RDY, 8'd0, "ramp_full_not_ready");
    expect_out(8'd200, 6'h0F, "ramp_unswapped_black");
    pulse_swap();
    expect_v(K_RDY, 8'd1, "ramp_swap_ready");
    expect_out(8'd200, 6'h08, "ramp_idx200");
    expect_out(8'd63, 6'h3F, "ramp_idx63");
    expect_out(8'd0, 6'h00, "ramp_idx0");

    // Line A then three underruns
    for (int i = 0; i < 256; i++) write_px(8'(i), 6'h21);
    pulse_done();
    pulse_swap();
    expect_out(8'd7, 6'h21, "lineA_out");
    repeat (3) pulse_swap();
    expect_out(8'd7, 6'h21, "lineA_after_underruns");
`ifdef SLBUF_STATS_EN
    expect_v(K_UND, 8'd3, "underrun_3");
`endif

    // Pulses while clock enable is low are lost
    i_clk_en = 1'b0;
    i_ppu_line_done = 1'b1;
    tick();
    i_ppu_line_done = 1'b0;
    i_vga_swap_req = 1'b1;
    tick();
    i_vga_swap_req = 1'b0;
    i_clk_en = 1'b1;
    expect_v(K_RDY, 8'd1, "clk_en_low_done_lost");
    expect_out(8'd7, 6'h21, "clk_en_low_swap_lost");
`ifdef SLBUF_STATS_EN
    expect_v(K_UND, 8'd3, "clk_en_low_underrun_hold");
`endif

    // Overrun: write bank (bank 0) still holds the ramp
    pulse_done();
    expect_v(K_RDY, 8'd0, "ovr_full");
    write_px(8'd10, 6'h05);
`ifdef SLBUF_STATS_EN
    expect_v(K_OVR, 8'd1, "ovr_write_sets");
    pulse_clr();
    expect_v(K_OVR, 8'd0, "ovr_clr");
    expect_v(K_UND, 8'd0, "und_clr");
    pulse_done();
    expect_v(K_OVR, 8'd1, "ovr_line_done_sets");
    i_stat_clr = 1'b1;
    write_px(8'd11, 6'h05);
    i_stat_clr = 1'b0;
    expect_v(K_OVR, 8'd0, "ovr_clr_priority");
`endif
    expect_v(K_RDY, 8'd0, "ovr_still_full");
    pulse_swap();
    expect_v(K_RDY, 8'd1, "ovr_swap_ready");
    expect_out(8'd10, 6'h0A, "ovr_write_dropped");

    // Line B with write + line_done + swap in one cycle
    for (int i = 0; i < 255; i++) write_px(8'(i), 6'h16);
    i_ppu_wr_en = 1'b1; i_ppu_wr_idx = 8'd255; i_ppu_wr_data = 6'h2A;
    i_ppu_line_done = 1'b1; i_vga_swap_req = 1'b1;
    tick();
    i_ppu_wr_en = 1'b0; i_ppu_line_done = 1'b0; i_vga_swap_req = 1'b0;
    expect_out(8'd100, 6'h16, "simul_lineB");
    expect_out(8'd255, 6'h2A, "simul_write_preswap_bank");
    expect_v(K_RDY, 8'd1, "simul_state_fill");
`ifdef SLBUF_STATS_EN
    expect_v(K_UND, 8'd0, "simul_no_underrun");
`endif

    // Saturation
    repeat (300) pulse_swap();
    expect_out(8'd100, 6'h16, "sat_out_hold");
`ifdef SLBUF_STATS_EN
    expect_v(K_UND, 8'hFF, "underrun_saturates");
`endif

    // Reset mid-line
    for (int i = 0; i < 4; i++) write_px(8'(i), 6'h01);
    #2;
    rst_n = 1'b0;
    expect_out(8'd100, 6'h0F, "midreset_black");
    expect_v(K_RDY, 8'd1, "midreset_ready");
`ifdef SLBUF_STATS_EN
    expect_v(K_UND, 8'd0, "midreset_underrun");
`endif
    rst_n = 1'b1;
    tick();
    pulse_swap();
    expect_out(8'd1, 6'h0F, "postreset_underrun_black");

    repeat (2) tick();
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scanline_buf_ctrl.md
# scanline_buf_ctrl

Ping-pong controller for the PPU→VGA scanline buffer. The PPU renders one 256-pixel line into a write bank. The VGA scanner reads the other bank through `vga_buf_idx`/`vga_buf_out`. Banks swap at a VGA line-pair boundary only when the PPU has completed a line. The block sits between the PPU pixel pipeline and the VGA timing module, owns both 256×6 banks, and rate-matches the two producers.

## Interface
- `LINE_W`, 256: pixels per line. Must be a power of two ≤ 256.
- `clk` in 1: system clock.
- `clk_en` in 1: clock enable. All state advances only when high.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `ppu_wr_en` in 1: write pixel strobe.
- `ppu_wr_idx` in 8: pixel column 0..255.
- `ppu_wr_data` in 6: palette index.
- `ppu_line_done` in 1: one-cycle pulse; the current write line is complete.
- `ppu_wr_ready` out 1: high when the write bank accepts pixels.
- `vga_swap_req` in 1: one-cycle pulse at the end of each VGA line pair.
- `vga_buf_idx` in 8: read column.
- `vga_buf_out` out 6: palette index at `vga_buf_idx`.
- `underrun_cnt` out 8: saturating count of swap requests with no line ready. Present only with the macro.
- `overrun` out 1: sticky; a write or `ppu_line_done` arrived while the bank was not ready. Present only with the macro.
- `stat_clr` in 1: clears both statistics. Present only with the macro.

## Operation
- Two banks, `bank[0]` and `bank[1]`, each `LINE_W`×6. The `rd_sel` register selects the read bank; the write bank is `~rd_sel`.
- Write-side FSM:
  - `SLB_FILL`: `ppu_wr_ready`=1.
    - `ppu_wr_en` writes `ppu_wr_data` to `bank[~rd_sel][ppu_wr_idx]`.
    - `ppu_line_done` → `SLB_FULL`.
  - `SLB_FULL`: `ppu_wr_ready`=0.
    - Writes are dropped and set `overrun`.
    - `ppu_line_done` is ignored and sets `overrun`.
- Swap on `vga_swap_req`:
  - In `SLB_FULL`: toggle `rd_sel`, set `primed`=1, go to `SLB_FILL`.
  - In `SLB_FILL`: no swap. The VGA re-reads the previous line. `underrun_cnt` increments and saturates at 255.
- Simultaneous events:
  - `ppu_line_done` and `vga_swap_req` in the same enabled cycle while in `SLB_FILL`: the line is committed and swapped that cycle. Next state is `SLB_FILL` with the new write bank. No underrun is counted.
  - `ppu_wr_en` with `ppu_line_done` in the same cycle: the write is performed, then the state changes.
  - `ppu_wr_en` with a swap in the same cycle: the write goes to the pre-swap write bank.
- Read path:
  - `vga_buf_out = primed ? bank[rd_sel][vga_buf_idx] : 6'h0F` (black).
  - Combinational, zero latency. It must not depend on `clk_en`.
- Index width: for `LINE_W` < 256, only the low log2(`LINE_W`) bits of each index are used. Writes wrap.

## Timing
- Reset values:
  - `rd_sel`=1 and `primed`=0, so `vga_buf_out`=6'h0F.
  - State `SLB_FILL`, so `ppu_wr_ready`=1.
  - `underrun_cnt`=0, `overrun`=0.
  - Bank contents are not reset.
- Write latency: data is visible in the bank one enabled edge after the strobe. It becomes readable only after the next swap.
- Swap latency: `vga_buf_out` reflects the new bank combinationally from the enabled edge that samples `vga_swap_req`.
- `ppu_wr_ready` changes on the enabled edge after `ppu_line_done` or after a swap.
- `clk_en`=0: all registers and bank writes hold. Pulses presented while `clk_en`=0 are lost; sources must hold them until an enabled cycle.
- Reset mid-line: the partially written line is discarded and the output returns to black until a full line is swapped in.
- `stat_clr` has priority over an increment or set in the same cycle.

## Configuration
- `SLBUF_STATS_EN` defined:
  - `underrun_cnt`, `overrun` and `stat_clr` ports and logic exist.
- Not defined:
  - Those ports are absent.
  - Underrun and overrun are handled silently with identical datapath behaviour.

## Structure
- Shared PPU package / `ppu_defines.vh` holds:
  - enum `slb_state_t {SLB_FILL, SLB_FULL}`
  - constant `SLB_BLACK` = 6'h0F
  - constant `SLB_LINE_W` = 256
- Sub-module `scanline_bank`: `LINE_W`×6 RAM with synchronous write and asynchronous read. It is instantiated twice.
- The controller holds the FSM, `rd_sel`, `primed` and the statistics.

## Test plan
- Reset, then `vga_buf_idx`=5 → `vga_buf_out`=0x0F, `ppu_wr_ready`=1, `underrun_cnt`=0.
- Write `data = idx & 0x3F` for idx 0..255, pulse `ppu_line_done`, pulse `vga_swap_req` → `ppu_wr_ready` 0 then 1; idx 200 reads 0x08, idx 63 reads 0x3F.
- Fill line A (all 0x21), swap; issue 3 swap requests with no `line_done` → output stays 0x21, `underrun_cnt`=3.
- In `SLB_FULL`, `ppu_wr_en` to idx 10 with data 0x05 → bank unchanged, `overrun`=1; `stat_clr` → `overrun`=0, `underrun_cnt`=0.
- Fill line B (0x16); `ppu_line_done` and `vga_swap_req` in the same cycle → output 0x16 next, state `SLB_FILL`, no underrun counted.
- 300 underruns → `underrun_cnt` saturates at 255. Assert `rst_n` mid-line → output 0x0F, `ppu_wr_ready`=1.
